// File: rtl/hwpe_ctrl_job_sched_if.sv
// Handshake bundle between the HWPE register-file front-end and the job scheduler.
// The scheduler side uses the slave modport; the front-end/bench uses master.
interface hwpe_ctrl_job_sched_if #(
  parameter int N_CONTEXT = 2,
  parameter int ID_WIDTH  = 16
);
  localparam int LOG_CXT = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;

  logic                clear_i;
  logic                acq_req_i;
  logic [ID_WIDTH-1:0] acq_id_i;
  logic                acq_rsp_valid_o;
  logic [31:0]         acq_rsp_o;
  logic                trig_i;
  logic [ID_WIDTH-1:0] trig_id_i;
  logic                done_i;
  logic                start_o;
  logic                lock_o;
  logic [ID_WIDTH-1:0] lock_owner_o;
  logic [LOG_CXT-1:0]  pointer_cxt_o;
  logic [LOG_CXT-1:0]  running_cxt_o;
  logic [7:0]          offload_job_id_o;
  logic [7:0]          running_job_id_o;
  logic [N_CONTEXT-1:0] cxt_busy_o;
  logic                evt_o;
  logic [1:0]          finished_cnt_o;
  logic                finished_clr_i;

  modport slave (
    input  clear_i, acq_req_i, acq_id_i, trig_i, trig_id_i, done_i, finished_clr_i,
    output acq_rsp_valid_o, acq_rsp_o, start_o, lock_o, lock_owner_o, pointer_cxt_o,
           running_cxt_o, offload_job_id_o, running_job_id_o, cxt_busy_o, evt_o,
           finished_cnt_o
  );

  modport master (
    output clear_i, acq_req_i, acq_id_i, trig_i, trig_id_i, done_i, finished_clr_i,
    input  acq_rsp_valid_o, acq_rsp_o, start_o, lock_o, lock_owner_o, pointer_cxt_o,
           running_cxt_o, offload_job_id_o, running_job_id_o, cxt_busy_o, evt_o,
           finished_cnt_o
  );
endinterface

// File: rtl/hwpe_ctrl_job_sched.sv
// Job-slot scheduler: acquire/trigger offload lock, circular queue of register
// contexts, engine start sequencing and completion counting.
module hwpe_ctrl_job_sched #(
  parameter int N_CONTEXT = 2,
  parameter int ID_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  hwpe_ctrl_job_sched_if.slave   bus
);
  localparam int LOG_CXT = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1;
  localparam int CNT_W   = LOG_CXT + 1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
  typedef enum logic [1:0] {IDLE, START, RUN} eng_state_e;

  lock_state_e          lock_q;
  eng_state_e           eng_q;
  logic [CNT_W-1:0]     cxt_cnt;
  logic [LOG_CXT-1:0]   ptr;
  logic [LOG_CXT-1:0]   run_ptr;
  logic [7:0]           off_id;
  logic [7:0]           run_id;
  logic [N_CONTEXT-1:0] busy;
  logic [N_CONTEXT-1:0] busy_nxt;
  logic [ID_WIDTH-1:0]  owner;
  logic [31:0]          rsp;
  logic                 rsp_vld;
  logic                 start;
  logic                 evt;
  logic [1:0]           fin;
  logic                 commit;
  logic                 accept_done;
  logic                 full;

  // Wraps modulo N_CONTEXT; for a single context the pointer stays at zero.
  function automatic logic [LOG_CXT-1:0] next_ptr(input logic [LOG_CXT-1:0] p);
    return (p == LOG_CXT'(N_CONTEXT - 1)) ? '0 : p + LOG_CXT'(1);
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd2) ? 2'd2 : c + 2'd1;
  endfunction

  always_comb begin
    commit      = (lock_q == LOCKED) && bus.trig_i && (bus.trig_id_i == owner);
    accept_done = (eng_q == RUN) && bus.done_i;
    full        = (cxt_cnt == CNT_W'(N_CONTEXT));
    busy_nxt    = busy;
    // A commit never targets the running slot while it is still busy, so order is irrelevant.
    if (commit)      busy_nxt[ptr]     = 1'b1;
    if (accept_done) busy_nxt[run_ptr] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear_i) begin
      lock_q  <= UNLOCKED;
      eng_q   <= IDLE;
      cxt_cnt <= '0;
      ptr     <= '0;
      run_ptr <= '0;
      off_id  <= '0;
      run_id  <= '0;
      busy    <= '0;
      owner   <= '0;
      rsp     <= '0;
      rsp_vld <= 1'b0;
      start   <= 1'b0;
      evt     <= 1'b0;
      fin     <= '0;
    end else begin
      rsp_vld <= bus.acq_req_i;
      evt     <= accept_done;
      busy    <= busy_nxt;

      // Acquire sees the pre-commit lock state, so a same-cycle trigger still yields -2.
      if (bus.acq_req_i) begin
        if (lock_q == LOCKED) begin
          rsp <= 32'hFFFF_FFFE;
        end else if (full) begin
          rsp <= 32'hFFFF_FFFF;
        end else begin
          rsp    <= {24'b0, off_id};
          lock_q <= LOCKED;
          owner  <= bus.acq_id_i;
        end
      end

      if (commit) begin
        ptr    <= next_ptr(ptr);
        off_id <= off_id + 8'd1;
        lock_q <= UNLOCKED;
      end

      case ({commit, accept_done})
        2'b10:   cxt_cnt <= cxt_cnt + CNT_W'(1);
        2'b01:   cxt_cnt <= cxt_cnt - CNT_W'(1);
        default: cxt_cnt <= cxt_cnt;
      endcase

      if (bus.finished_clr_i)  fin <= '0;
      else if (accept_done)    fin <= sat_inc(fin);

      start <= 1'b0;
      case (eng_q)
        IDLE: begin
          if (cxt_cnt != '0) begin
            eng_q <= START;
            start <= 1'b1;
          end
        end
        START: eng_q <= RUN;
        RUN: begin
          if (bus.done_i) begin
            eng_q   <= IDLE;
            run_ptr <= next_ptr(run_ptr);
            run_id  <= run_id + 8'd1;
          end
        end
        default: eng_q <= IDLE;
      endcase
    end
  end

  assign bus.acq_rsp_valid_o  = rsp_vld;
  assign bus.acq_rsp_o        = rsp;
  assign bus.start_o          = start;
  assign bus.lock_o           = (lock_q == LOCKED);
  assign bus.lock_owner_o     = owner;
  assign bus.pointer_cxt_o    = ptr;
  assign bus.running_cxt_o    = run_ptr;
  assign bus.offload_job_id_o = off_id;
  assign bus.running_job_id_o = run_id;
  assign bus.cxt_busy_o       = busy;
  assign bus.evt_o            = evt;
  assign bus.finished_cnt_o   = fin;

endmodule
